// File: rtl/cpu_sel_defs.sv
// Shared select-code definitions for the CPU source mux and destination demux.
package cpu_sel_defs;
   localparam int DATA_W = 8;
   localparam int NUM_CH = 6;

   localparam logic [2:0] SEL_CH0   = 3'b000;
   localparam logic [2:0] SEL_CH1   = 3'b001;
   localparam logic [2:0] SEL_CH2   = 3'b010;
   localparam logic [2:0] SEL_CH3   = 3'b011;
   localparam logic [2:0] SEL_CH4   = 3'b100;
   localparam logic [2:0] SEL_CH5   = 3'b101;
   localparam logic [2:0] SEL_BCAST = 3'b111;

   typedef logic [DATA_W-1:0] data_t;

   function automatic logic sel_is_channel(input logic [2:0] s);
      return (s <= SEL_CH5);
   endfunction
endpackage

// File: rtl/demux_slot_8bit.sv
// One-entry holding buffer for a single demux channel with valid/ack handshake.
module demux_slot_8bit
   import cpu_sel_defs::*;
(
   input  logic  i_clock,
   input  logic  i_reset,
   input  logic  i_load,
   input  logic  i_ack,
   input  data_t i_d,
   output data_t o_q,
   output logic  o_full,
   output logic  o_free
);
   data_t r_q;
   logic  r_full;

   // A load in the same cycle as an ack wins: the slot stays full with new data.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_q    <= '0;
         r_full <= 1'b0;
      end else if (i_load) begin
         r_q    <= i_d;
         r_full <= 1'b1;
      end else if (i_ack) begin
         r_full <= 1'b0;
      end
   end

   assign o_q    = r_q;
   assign o_full = r_full;
   assign o_free = !r_full || i_ack;
endmodule

// File: rtl/demux1to6_8bit.sv
// Registered 1-to-6 demux with per-channel holding buffers, transfer counter and
// sticky illegal-select flag. Define DEMUX_BROADCAST_EN to make sel=3'b111 broadcast.
module demux1to6_8bit
   import cpu_sel_defs::*;
(
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [7:0]  i_data_in,
   input  logic [2:0]  i_sel,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   output logic [7:0]  o_data0x,
   output logic [7:0]  o_data1x,
   output logic [7:0]  o_data2x,
   output logic [7:0]  o_data3x,
   output logic [7:0]  o_data4x,
   output logic [7:0]  o_data5x,
   output logic [5:0]  o_out_valid,
   input  logic [5:0]  i_out_ack,
   output logic [7:0]  o_xfer_count,
   output logic        o_sel_error
);
   logic [NUM_CH-1:0]             w_free;
   logic [NUM_CH-1:0]             w_load;
   logic [NUM_CH-1:0][DATA_W-1:0] w_q;
   logic                          w_legal;
   logic                          w_bcast;
   logic                          w_ready;
   logic                          w_fire;
   logic [7:0]                    r_xfer_count;
   logic                          r_sel_error;

   // Illegal codes are always ready so a bad producer can never stall the bus.
   always_comb begin
      w_legal = 1'b0;
      w_bcast = 1'b0;
      w_ready = 1'b1;
      if (sel_is_channel(i_sel)) begin
         w_legal = 1'b1;
         w_ready = w_free[i_sel];
      end
`ifdef DEMUX_BROADCAST_EN
      else if (i_sel == SEL_BCAST) begin
         w_bcast = 1'b1;
         w_ready = &w_free;
      end
`endif
   end

   assign w_fire = i_in_valid && w_ready;

   always_comb begin
      w_load = '0;
      if (w_fire && w_legal) w_load[i_sel] = 1'b1;
      if (w_fire && w_bcast) w_load = '1;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
         demux_slot_8bit u_slot (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_load  (w_load[gi]),
            .i_ack   (i_out_ack[gi]),
            .i_d     (i_data_in),
            .o_q     (w_q[gi]),
            .o_full  (o_out_valid[gi]),
            .o_free  (w_free[gi])
         );
      end
   endgenerate

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_xfer_count <= '0;
         r_sel_error  <= 1'b0;
      end else if (w_fire) begin
         if (w_legal || w_bcast) r_xfer_count <= r_xfer_count + 8'd1;
         else                    r_sel_error  <= 1'b1;
      end
   end

   assign o_in_ready   = w_ready;
   assign o_xfer_count = r_xfer_count;
   assign o_sel_error  = r_sel_error;
   assign o_data0x     = w_q[0];
   assign o_data1x     = w_q[1];
   assign o_data2x     = w_q[2];
   assign o_data3x     = w_q[3];
   assign o_data4x     = w_q[4];
   assign o_data5x     = w_q[5];
endmodule

// File: tb/tb_demux1to6_8bit.sv
// Directed scoreboard bench for demux1to6_8bit; expected state queued per driven cycle.
module tb_demux1to6_8bit;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_in = '0;
   logic [2:0] sel = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] d0, d1, d2, d3, d4, d5;
   logic [5:0] out_valid;
   logic [5:0] out_ack = '0;
   logic [7:0] xfer_count;
   logic       sel_error;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:0][7:0] d;
      logic [5:0]      v;
      logic [7:0]      cnt;
      logic            err;
   } snap_t;

   snap_t q[$];
   snap_t m;

   demux1to6_8bit dut (
      .i_clock(clk), .i_reset(rst), .i_data_in(data_in), .i_sel(sel),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .o_data0x(d0), .o_data1x(d1), .o_data2x(d2), .o_data3x(d3),
      .o_data4x(d4), .o_data5x(d5), .o_out_valid(out_valid),
      .i_out_ack(out_ack), .o_xfer_count(xfer_count), .o_sel_error(sel_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_ready(input logic [2:0] s, input logic [5:0] ack);
      logic [5:0] fr;
      fr = ~m.v | ack;
      if (s <= 3'd5) return fr[s];
`ifdef DEMUX_BROADCAST_EN
      if (s == 3'b111) return &fr;
`endif
      return 1'b1;
   endfunction

   // Drive one cycle, check in_ready before the edge, then compare queued state after.
   task automatic step(input logic [7:0] dv, input logic [2:0] s, input logic v, input logic [5:0] ack);
      logic  rdy;
      snap_t got, e;
      data_in = dv; sel = s; in_valid = v; out_ack = ack;
      rdy = model_ready(s, ack);
      #3;
      chk("in_ready", in_ready, rdy);
      for (int i = 0; i < 6; i++)
         if (ack[i]) m.v[i] = 1'b0;
      if (v && rdy) begin
         if (s <= 3'd5) begin
            m.v[s] = 1'b1; m.d[s] = dv; m.cnt++;
         end
`ifdef DEMUX_BROADCAST_EN
         else if (s == 3'b111) begin
            m.v = '1; for (int i = 0; i < 6; i++) m.d[i] = dv; m.cnt++;
         end
`endif
         else m.err = 1'b1;
      end
      q.push_back(m);
      @(posedge clk); #1;
      e = q.pop_front();
      got.d = {d5, d4, d3, d2, d1, d0};
      chk("data", got.d[5:4], e.d[5:4]);
      chk("data", got.d[3:0], e.d[3:0]);
      chk("out_valid", out_valid, e.v);
      chk("xfer_count", xfer_count, e.cnt);
      chk("sel_error", sel_error, e.err);
      in_valid = 1'b0; out_ack = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b1; sel = 3'd1; data_in = 8'h77; out_ack = '1;
      m.d = '0; m.v = '0; m.cnt = '0; m.err = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ack = '0;
      chk("rst_valid", out_valid, 6'b0);
      chk("rst_data", {d5, d4, d3, d2}, 32'h0);
      chk("rst_data01", {d1, d0}, 16'h0);
      chk("rst_count", xfer_count, 8'h00);
      chk("rst_err", sel_error, 1'b0);
   endtask

   initial begin
      logic [7:0] c0;
      @(posedge clk); #1;
      do_reset();

      step(8'hA5, 3'd2, 1'b1, 6'b0);
      chk("tp1_d2", d2, 8'hA5);
      chk("tp1_valid", out_valid, 6'b000100);
      chk("tp1_cnt", xfer_count, 8'd1);

      step(8'h3C, 3'd2, 1'b1, 6'b0);
      chk("tp2_hold", d2, 8'hA5);
      step(8'h3C, 3'd2, 1'b1, 6'b000100);
      chk("tp2_ackwr_d2", d2, 8'h3C);
      chk("tp2_ackwr_v2", out_valid[2], 1'b1);

      step(8'h99, 3'd5, 1'b1, 6'b0);
      step(8'h11, 3'd0, 1'b1, 6'b100000);
      chk("tp3_v0", out_valid[0], 1'b1);
      chk("tp3_v5", out_valid[5], 1'b0);
      chk("tp3_d5", d5, 8'h99);

      step(8'h00, 3'd1, 1'b0, 6'b000010);
      step(8'h00, 3'd0, 1'b0, 6'b111111);
      chk("clear_all", out_valid, 6'b0);

      step(8'h5A, 3'd7, 1'b1, 6'b0);
`ifdef DEMUX_BROADCAST_EN
      chk("bc_valid", out_valid, 6'b111111);
      chk("bc_d4", d4, 8'h5A);
      chk("bc_err", sel_error, 1'b0);
      step(8'h33, 3'd7, 1'b1, 6'b101111);
      chk("bc_stall_v4", out_valid[4], 1'b1);
      step(8'h00, 3'd0, 1'b0, 6'b111111);
`else
      chk("b7_err", sel_error, 1'b1);
      chk("b7_valid", out_valid, 6'b0);
`endif

      c0 = xfer_count;
      step(8'hFF, 3'd6, 1'b1, 6'b0);
      chk("ill_err", sel_error, 1'b1);
      chk("ill_cnt", xfer_count, c0);
      chk("ill_valid", out_valid, 6'b0);
      step(8'h42, 3'd3, 1'b1, 6'b0);
      chk("err_sticky", sel_error, 1'b1);

      c0 = xfer_count;
      for (int i = 0; i < 256; i++)
         step(8'(i * 7), 3'(i % 6), 1'b1, 6'b111111);
      chk("wrap_cnt", xfer_count, c0);

      step(8'hEE, 3'd4, 1'b1, 6'b0);
      do_reset();
      chk("rst_clears_err", sel_error, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/demux1to6_8bit.md
# demux1to6_8bit

Registered 1-to-6 demultiplexer for the simple CPU datapath, the write-side counterpart of the 8-bit source-select mux: one 8-bit producer stream is steered by a 3-bit select code onto one of six 8-bit destination channels. Each channel is a one-entry holding buffer with valid/ack handshake, so a slow consumer back-pressures the producer. The block also keeps a transfer counter and a sticky error flag for illegal select codes.

## Interface
- No parameters; width (8) and channel count (6) are fixed.
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-high reset
- data_in  input  8  producer data word
- sel  input  3  destination code: 3'b000..3'b101 = channel 0..5
- in_valid  input  1  producer offers data_in/sel this cycle
- in_ready  output  1  combinational; transfer occurs when in_valid && in_ready
- data0x..data5x  output  8 each  registered channel data
- out_valid  output  6  bit i = data{i}x holds an unconsumed word
- out_ack  input  6  bit i = consumer takes data{i}x this cycle
- xfer_count  output  8  accepted-transfer counter
- sel_error  output  1  sticky illegal-select flag

## Operation
- Per channel i: full flag out_valid[i], data register data{i}x.
- free[i] = !out_valid[i] || out_ack[i] (ack in the same cycle frees the slot).
- Legal sel (0..5): in_ready = free[sel]. On transfer: data{sel}x <= data_in, out_valid[sel] <= 1.
- Channel i not written but out_ack[i] && out_valid[i]: out_valid[i] <= 0; data{i}x holds its last value.
- Simultaneous ack and write on the same channel: write wins; out_valid stays 1 with the new data.
- out_ack[i] while out_valid[i]=0: ignored.
- Illegal sel (3'b110, and 3'b111 unless broadcast is compiled in): in_ready = 1; word accepted and dropped; sel_error <= 1; no channel changes; xfer_count unchanged.
- xfer_count increments by 1 per legal transfer; wraps 8'hFF -> 8'h00.
- sel_error clears only on reset.
- in_ready depends on sel and out_ack only, never on in_valid.

## Timing
- Reset (clock edge with reset=1): data0x..data5x = 8'h00, out_valid = 6'b0, xfer_count = 8'h00, sel_error = 0. Reset overrides any transfer or ack in the same cycle.
- Latency: a word accepted at edge N appears on data{sel}x with out_valid set after edge N; visible through cycle N+1.
- Throughput: one word per clock when the target channel is free or acked in the same cycle.
- Back-pressure: in_ready low holds the producer; the producer keeps data_in/sel stable until acceptance.
- Reset mid-stream: all held words are discarded; no partial state survives.

## Configuration
- DEMUX_BROADCAST_EN defined: sel = 3'b111 is broadcast. in_ready = &free. On transfer, all six channels load data_in and set out_valid. xfer_count += 1. sel_error is not set.
- DEMUX_BROADCAST_EN undefined: 3'b111 is illegal and handled as described under Operation.

## Structure
- Shared package/header cpu_sel_defs: select-code constants SEL_CH0..SEL_CH5 and SEL_BCAST (3'b111), channel count 6, data width 8. The CPU mux and this block both use it.
- Sub-module demux_slot_8bit: one channel (data register, full flag, free output; inputs load, ack, d). Instantiated six times. The top level holds the select decode, the in_ready mux, the counter and the error flag.

## Test plan
- Reset, then sel=3'b010 with data_in=8'hA5 and in_valid=1, no acks -> next cycle data2x=8'hA5, out_valid=6'b000100, xfer_count=1.
- Channel 2 full, second word 8'h3C to sel=2, out_ack=0 -> in_ready=0 and data2x stays 8'hA5. Then out_ack[2]=1 in the same cycle -> accepted, data2x=8'h3C, out_valid[2] stays 1.
- Write 8'h11 to channel 0 and ack channel 5 (full) in the same cycle -> out_valid[0]=1, out_valid[5]=0, data5x unchanged.
- sel=3'b110, data_in=8'hFF -> in_ready=1, sel_error=1, no data or valid change, xfer_count unchanged; sel_error stays 1 until reset.
- 256 legal transfers with acks -> xfer_count returns to 8'h00.
- With DEMUX_BROADCAST_EN: sel=3'b111, data_in=8'h5A, all channels free -> all data{i}x=8'h5A, out_valid=6'b111111, xfer_count +1. With channel 4 full and unacked -> in_ready=0. Without the macro -> the word is dropped and sel_error=1.
